fxp_acc_ctrl: RTL

//  Sequencer/arbiter that shares one fixed-point accumulator instance among N_REQ requesters.

---
 rtl/fxp_acc_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/fxp_acc_ctrl.sv
// fxp_acc_ctrl: shares one external fixed-point accumulator among N_REQ
// requesters. Jobs are granted round-robin; each job clears the accumulator,
// streams req_len+1 samples into it, then returns the sum, the overflow flag
// and the owning requester id through a valid/ready result port.
//
// Build option: define FXP_ACC_CTRL_ABORT_EN to stop feeding the accumulator
// once it reports overflow during a job. The remaining samples are still
// accepted so the requester's stream stays in step with the job length.
module fxp_acc_ctrl #(
  parameter int N_REQ  = 4,
  parameter int WL_IN  = 32,
  parameter int WL_OUT = 32,
  parameter int LEN_W  = 8,
  parameter int ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  input  logic                   s_valid,
  input  logic [WL_IN-1:0]       s_data,
  output logic                   s_ready,
  output logic [WL_IN-1:0]       acc_din,
  output logic                   acc_rst_n,
  input  logic [WL_OUT-1:0]      acc_dout,
  input  logic                   acc_ovf,
  output logic                   r_valid,
  output logic [WL_OUT-1:0]      r_data,
  output logic                   r_ovf,
  output logic [ID_W-1:0]        r_id,
  input  logic                   r_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   cnt_reg, cnt_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               r_valid_reg, r_valid_next;
  logic [WL_OUT-1:0]  r_data_reg, r_data_next;
  logic               r_ovf_reg, r_ovf_next;
  logic [ID_W-1:0]    r_id_reg, r_id_next;

  // Per-requester length fields, unpacked for indexing by the winner id.
  logic [LEN_W-1:0]   len_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_len
      assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Round-robin pick: lowest requester at or above the pointer, otherwise
  // wrap around to the lowest requester overall.
  logic               sel_found;
  logic               hi_found;
  logic [ID_W-1:0]    hi_id;
  logic [ID_W-1:0]    lo_id;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    sel_ptr;

  // Arbiter: scan downward so the lowest qualifying index is written last.
  always_comb begin
    sel_found = 1'b0;
    hi_found  = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        sel_found = 1'b1;
        lo_id     = ID_W'(i);
        if (ID_W'(i) >= ptr_reg) begin
          hi_found = 1'b1;
          hi_id    = ID_W'(i);
        end
      end
    end
    sel_id  = hi_found ? hi_id : lo_id;
    sel_ptr = (sel_id == ID_W'(N_REQ - 1)) ? '0 : sel_id + 1'b1;
  end

  // Next-state and register-update logic for the job sequencer.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    id_next      = id_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    r_valid_next = r_valid_reg;
    r_data_next  = r_data_reg;
    r_ovf_next   = r_ovf_reg;
    r_id_next    = r_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          id_next    = sel_id;
          cnt_next   = len_arr[sel_id];
          ptr_next   = sel_ptr;
          gnt_next   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_id;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        // s_ready is high throughout RUN, so s_valid alone marks a transfer.
        if (s_valid) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == '0) begin
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Accumulator output now includes the final sample.
        r_data_next  = acc_dout;
        r_ovf_next   = acc_ovf;
        r_id_next    = id_reg;
        r_valid_next = 1'b1;
        gnt_next     = '0;
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        if (r_ready) begin
          r_valid_next = 1'b0;
          state_next   = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      id_reg      <= '0;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_ovf_reg   <= 1'b0;
      r_id_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      id_reg      <= id_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      r_valid_reg <= r_valid_next;
      r_data_reg  <= r_data_next;
      r_ovf_reg   <= r_ovf_next;
      r_id_reg    <= r_id_next;
    end
  end

  // Handshake outputs are forced low while reset is asserted so that no
  // transfer can be seen in the cycle the reset arrives.
  logic accept;

  assign s_ready   = rst & (state_reg == ST_RUN);
  assign accept    = s_valid & s_ready;
  assign acc_rst_n = rst & (state_reg != ST_CLEAR);
  assign gnt       = rst ? gnt_reg : '0;
  assign r_valid   = rst & r_valid_reg;
  assign r_data    = r_data_reg;
  assign r_ovf     = r_ovf_reg;
  assign r_id      = r_id_reg;

`ifdef FXP_ACC_CTRL_ABORT_EN
  // Once the accumulator overflows, feed zeros for the rest of the job.
  assign acc_din = (accept & ~acc_ovf) ? s_data : '0;
`else
  // Every accepted sample reaches the accumulator; idle cycles feed zero.
  assign acc_din = accept ? s_data : '0;
`endif

endmodule
